utils_adder_pipe: RTL and testbench
===================================

Name: utils_adder_pipe

Overview:
Parametrised, pipelined successor to the 32-bit combinational carry-select adder in utils.
- Adds or subtracts two WIDTH-bit operands, using carry-select blocks inside each pipeline segment.
- Splits the carry chain across STAGES register stages, with valid/ready flow control and a synchronous flush.
- Used by the execute stage for wide address/ALU arithmetic and by multi-cycle units that need a timing-closed adder.

Parameters:
WIDTH, 32, operand/result width; legal 8..64.
STAGES, 2, pipeline register stages = result latency; legal 1..8, STAGES <= WIDTH/4.
BLK, 4, carry-select block size inside a segment; legal 2..8.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
flush_i  in  1  synchronous kill of all in-flight operations.
in_valid_i  in  1  operands valid.
in_ready_o  out  1  block can accept this cycle.
a_i  in  WIDTH  operand A.
b_i  in  WIDTH  operand B.
cin_i  in  1  carry in (add mode only).
sub_i  in  1  1 = A - B, 0 = A + B + cin.
out_valid_o  out  1  result valid.
out_ready_i  in  1  consumer accepts result.
sum_o  out  WIDTH  result.
cout_o  out  1  carry out; for sub, 1 = no borrow.
ovf_o  out  1  signed overflow (present only with UTILS_ADDER_PIPE_FLAGS_EN).
zero_o  out  1  sum_o == 0 (present only with UTILS_ADDER_PIPE_FLAGS_EN).

Behaviour:
Reset and handshake:
- Reset (rst_n low, async): all stage valid bits, sum_o, cout_o, ovf_o and zero_o go to 0. in_ready_o = 1 once reset deasserts.
- Global advance: adv = ~out_valid_o | out_ready_i.
- in_ready_o = adv (combinational from out_ready_i and state only; no path from in_valid_i).
- Accept happens when in_valid_i & in_ready_o. When adv = 0 every stage holds and outputs stay stable.
- Bubbles are not collapsed: a stage's valid bit shifts with adv exactly like its data.

Arithmetic and segmentation:
- Effective operands: b_eff = sub_i ? ~b_i : b_i; c0 = sub_i ? 1 : cin_i.
- Segment width SEG = ceil(WIDTH/STAGES). Segment k covers bits [k*SEG, min((k+1)*SEG, WIDTH)-1]; the last segment may be narrower.
- Stage k computes segment k with carry-select blocks of BLK bits. It uses the carry registered from stage k-1 (c0 for k=0) and registers its segment sum and carry-out.
- Operand skew: bits of not-yet-computed segments travel forward in registers. Already-computed sum bits are delayed, so every bit of one operation leaves on the same cycle.
- Latency: exactly STAGES cycles from accept to out_valid_o, given out_ready_i held high. Throughput: 1 op/cycle.
- STAGES = 1: a single registered carry-select adder; latency 1.
- cout_o = carry out of bit WIDTH-1; result is mod 2^WIDTH.

Flush:
- flush_i clears every valid bit on the next edge and blocks acceptance that cycle, even if in_valid_i & in_ready_o.
- Data registers may keep stale values, but out_valid_o = 0 the cycle after flush.
- Flush has priority over out_ready_i; a result presented in the flush cycle counts as dropped unless out_ready_i was also high that cycle (then it counts as consumed).

Mid-operation reset: all in-flight ops are lost; no output is produced for them after reset is released.

Optional Feature:
UTILS_ADDER_PIPE_FLAGS_EN:
- Defined: ovf_o and zero_o exist.
  - ovf_o = (a[W-1] == b_eff[W-1]) & (sum[W-1] != a[W-1]), computed in the final stage from skewed sign bits.
  - zero_o = ~|sum_o, registered with the result.
  - Both are valid only when out_valid_o = 1 and reset to 0.
- Undefined: neither port exists, no flag logic is built, and all other behaviour is identical.

Test Plan:
1. WIDTH=32, STAGES=2, a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0 -> 2 cycles later sum=0x00000000, cout=1, zero=1, ovf=0.
2. sub=1, a=0x00000005, b=0x00000007 -> sum=0xFFFFFFFE, cout=0 (borrow); then a=0x80000000, b=0x00000001, sub=1 -> sum=0x7FFFFFFF, ovf=1, cout=1.
3. Back-to-back stream of 100 random ops with out_ready_i=1 -> one result per cycle in order, each matching the reference model, first result at cycle 2.
4. Hold out_ready_i=0 for 5 cycles with the pipe full -> in_ready_o=0 and outputs stable; release -> no op lost or duplicated.
5. Assert flush_i with 2 ops in flight and in_valid_i=1 -> out_valid_o=0 next cycle, the flush-cycle op is not accepted, and a new op after flush completes correctly.
6. Sweep WIDTH=64/STAGES=4/BLK=3 and WIDTH=8/STAGES=1 with carry chains (0x7F..F + 1), plus async reset mid-stream -> latency equals STAGES, no spurious out_valid_o after reset.

Source files
------------

// File: rtl/utils_adder_pipe.sv
`default_nettype none
// ============================================================================
// Module   : utils_adder_pipe
// Brief    : Pipelined add/sub; carry chain split over STAGES segments built
//            from BLK-bit carry-select blocks. Flags via UTILS_ADDER_PIPE_FLAGS_EN.
// Revision : 1.0
// ============================================================================
module utils_adder_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int BLK    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             sub_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
`ifdef UTILS_ADDER_PIPE_FLAGS_EN
  ,
  output logic             ovf_o,
  output logic             zero_o
`endif
);

  localparam int c_SEG = (WIDTH + STAGES - 1) / STAGES;

  logic             valid_q [STAGES];
  logic [WIDTH-1:0] a_q     [STAGES];
  logic [WIDTH-1:0] b_q     [STAGES];
  logic [WIDTH-1:0] sum_q   [STAGES];
  logic             c_q     [STAGES];

  logic [WIDTH-1:0] stg_a   [STAGES];
  logic [WIDTH-1:0] stg_b   [STAGES];
  logic [WIDTH-1:0] stg_s   [STAGES];
  logic             stg_c   [STAGES];
  logic [WIDTH-1:0] sum_d   [STAGES];
  logic             c_d     [STAGES];

  logic             adv;

  assign adv         = ~out_valid_o | out_ready_i;
  assign in_ready_o  = adv;
  assign out_valid_o = valid_q[STAGES-1];
  assign sum_o       = sum_q[STAGES-1];
  assign cout_o      = c_q[STAGES-1];

  assign stg_a[0] = a_i;
  assign stg_b[0] = sub_i ? ~b_i : b_i;
  assign stg_c[0] = sub_i | cin_i;
  assign stg_s[0] = '0;

  // Stage k sees the operands and partial sum registered by stage k-1.
  for (genvar k = 1; k < STAGES; k++) begin : g_skew
    assign stg_a[k] = a_q[k-1];
    assign stg_b[k] = b_q[k-1];
    assign stg_s[k] = sum_q[k-1];
    assign stg_c[k] = c_q[k-1];
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = (k * c_SEG < WIDTH) ? k * c_SEG : WIDTH;
    localparam int HI = ((k + 1) * c_SEG < WIDTH) ? (k + 1) * c_SEG : WIDTH;

    logic [WIDTH-1:0] blk_s0;
    logic [WIDTH-1:0] blk_s1;
    logic [WIDTH-1:0] seg_s;
    logic             blk_c0;
    logic             blk_c1;
    logic             seg_c;

    // Each block precomputes both carry-in cases; the incoming carry selects.
    always_comb begin
      seg_s  = stg_s[k];
      seg_c  = stg_c[k];
      blk_s0 = '0;
      blk_s1 = '0;
      blk_c0 = 1'b0;
      blk_c1 = 1'b1;
      for (int lo = LO; lo < HI; lo += BLK) begin
        blk_c0 = 1'b0;
        blk_c1 = 1'b1;
        for (int i = lo; (i < lo + BLK) && (i < HI); i++) begin
          blk_s0[i] = stg_a[k][i] ^ stg_b[k][i] ^ blk_c0;
          blk_c0    = (stg_a[k][i] & stg_b[k][i]) | (blk_c0 & (stg_a[k][i] ^ stg_b[k][i]));
          blk_s1[i] = stg_a[k][i] ^ stg_b[k][i] ^ blk_c1;
          blk_c1    = (stg_a[k][i] & stg_b[k][i]) | (blk_c1 & (stg_a[k][i] ^ stg_b[k][i]));
        end
        for (int i = lo; (i < lo + BLK) && (i < HI); i++) begin
          seg_s[i] = seg_c ? blk_s1[i] : blk_s0[i];
        end
        seg_c = seg_c ? blk_c1 : blk_c0;
      end
    end

    assign sum_d[k] = seg_s;
    assign c_d[k]   = seg_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
        a_q[k]     <= '0;
        b_q[k]     <= '0;
        sum_q[k]   <= '0;
        c_q[k]     <= 1'b0;
      end
    end else begin
      if (adv) begin
        for (int k = 0; k < STAGES; k++) begin
          a_q[k]   <= stg_a[k];
          b_q[k]   <= stg_b[k];
          sum_q[k] <= sum_d[k];
          c_q[k]   <= c_d[k];
        end
      end
      // Valid bits shift in lockstep with data so bubbles are preserved.
      if (flush_i) begin
        for (int k = 0; k < STAGES; k++) begin
          valid_q[k] <= 1'b0;
        end
      end else if (adv) begin
        valid_q[0] <= in_valid_i;
        for (int k = 1; k < STAGES; k++) begin
          valid_q[k] <= valid_q[k-1];
        end
      end
    end
  end

`ifdef UTILS_ADDER_PIPE_FLAGS_EN
  logic ovf_d;
  logic zero_d;
  logic ovf_q;
  logic zero_q;

  assign ovf_d  = (stg_a[STAGES-1][WIDTH-1] == stg_b[STAGES-1][WIDTH-1]) &
                  (sum_d[STAGES-1][WIDTH-1] != stg_a[STAGES-1][WIDTH-1]);
  assign zero_d = ~|sum_d[STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (adv) begin
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign ovf_o  = ovf_q;
  assign zero_o = zero_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_utils_adder_pipe.sv
`default_nettype none
// tb_utils_adder_pipe: directed vectors on 32/2/4, 64/4/3 and 8/1/4 instances,
// with an in-order expectation queue on the 32-bit instance.
module tb_utils_adder_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        pa_fl, pa_iv, pa_ir, pa_ov, pa_or, pa_cin, pa_sub, pa_co;
  logic [31:0] pa_a, pa_b, pa_s;
  logic        pb_fl, pb_iv, pb_ir, pb_ov, pb_or, pb_cin, pb_sub, pb_co;
  logic [63:0] pb_a, pb_b, pb_s;
  logic        pc_fl, pc_iv, pc_ir, pc_ov, pc_or, pc_cin, pc_sub, pc_co;
  logic [7:0]  pc_a, pc_b, pc_s;
`ifdef UTILS_ADDER_PIPE_FLAGS_EN
  logic pa_ovf, pa_zero, pb_ovf, pb_zero, pc_ovf, pc_zero;
`endif

  utils_adder_pipe #(.WIDTH(32), .STAGES(2), .BLK(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .flush_i(pa_fl), .in_valid_i(pa_iv), .in_ready_o(pa_ir),
    .a_i(pa_a), .b_i(pa_b), .cin_i(pa_cin), .sub_i(pa_sub), .out_valid_o(pa_ov),
    .out_ready_i(pa_or), .sum_o(pa_s), .cout_o(pa_co)
`ifdef UTILS_ADDER_PIPE_FLAGS_EN
    , .ovf_o(pa_ovf), .zero_o(pa_zero)
`endif
  );

  utils_adder_pipe #(.WIDTH(64), .STAGES(4), .BLK(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .flush_i(pb_fl), .in_valid_i(pb_iv), .in_ready_o(pb_ir),
    .a_i(pb_a), .b_i(pb_b), .cin_i(pb_cin), .sub_i(pb_sub), .out_valid_o(pb_ov),
    .out_ready_i(pb_or), .sum_o(pb_s), .cout_o(pb_co)
`ifdef UTILS_ADDER_PIPE_FLAGS_EN
    , .ovf_o(pb_ovf), .zero_o(pb_zero)
`endif
  );

  utils_adder_pipe #(.WIDTH(8), .STAGES(1), .BLK(4)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .flush_i(pc_fl), .in_valid_i(pc_iv), .in_ready_o(pc_ir),
    .a_i(pc_a), .b_i(pc_b), .cin_i(pc_cin), .sub_i(pc_sub), .out_valid_o(pc_ov),
    .out_ready_i(pc_or), .sum_o(pc_s), .cout_o(pc_co)
`ifdef UTILS_ADDER_PIPE_FLAGS_EN
    , .ovf_o(pc_ovf), .zero_o(pc_zero)
`endif
  );

  int n_vec = 0;
  int n_err = 0;
  int cur   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] s;
    logic        c;
  } vec_t;

  // a, b, cin, sub, expected sum, expected carry-out
  function automatic vec_t vec(input int i);
    vec_t v;
    case (i)
      0:  v = {32'h00000001, 32'h00000002, 1'b0, 1'b0, 32'h00000003, 1'b0};
      1:  v = {32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0};
      2:  v = {32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0};
      3:  v = {32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1};
      4:  v = {32'h00000010, 32'h00000010, 1'b0, 1'b1, 32'h00000000, 1'b1};
      5:  v = {32'hDEADBEEF, 32'h00000001, 1'b0, 1'b0, 32'hDEADBEF0, 1'b0};
      6:  v = {32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1};
      7:  v = {32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0};
      8:  v = {32'h00000000, 32'h00000001, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0};
      9:  v = {32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1, 1'b0, 32'h00000000, 1'b1};
      10: v = {32'h0000FFFF, 32'h0000FFFF, 1'b0, 1'b0, 32'h0001FFFE, 1'b0};
      11: v = {32'h12345678, 32'h12345679, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0};
      12: v = {32'h00000003, 32'h00000001, 1'b1, 1'b1, 32'h00000002, 1'b1};
      13: v = {32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1};
      14: v = {32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0};
      15: v = {32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1};
      default: v = '0;
    endcase
    return v;
  endfunction

  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        o;
  } res_t;

  res_t exp_q[$];

  // Transfers are decided by the levels seen here, ahead of the next edge.
  always @(negedge clk) begin : mon
    res_t e;
    vec_t v;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() == 0) chk("idle_out_valid", 64'(pa_ov), 64'd0);
      if (pa_ov && pa_or && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("stream_result", 64'({pa_co, pa_s}), 64'({e.c, e.s}));
`ifdef UTILS_ADDER_PIPE_FLAGS_EN
        chk("stream_ovf", 64'(pa_ovf), 64'(e.o));
        chk("stream_zero", 64'(pa_zero), 64'(e.s == 32'd0));
`endif
      end
      if (pa_fl) begin
        exp_q.delete();
      end else if (pa_iv && pa_ir) begin
        v   = vec(cur);
        e.s = v.s;
        e.c = v.c;
        e.o = (v.a[31] == (v.sub ? ~v.b[31] : v.b[31])) && (v.s[31] != v.a[31]);
        exp_q.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input int i);
    vec_t v;
    v      = vec(i);
    cur    = i;
    pa_a   = v.a;
    pa_b   = v.b;
    pa_cin = v.cin;
    pa_sub = v.sub;
    pa_iv  = 1'b1;
  endtask

  task automatic drive(input int i);
    present(i);
    tick();
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 20 && exp_q.size() != 0; n++) tick();
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic run_b(input string tag, input logic [63:0] a, input logic [63:0] b,
                       input logic ci, input logic sb, input logic [63:0] es, input logic ec);
    int lat;
    pb_a = a; pb_b = b; pb_cin = ci; pb_sub = sb; pb_iv = 1'b1;
    tick();
    pb_iv = 1'b0;
    lat   = 1;
    while (!pb_ov && lat < 12) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'd4);
    chk({tag, "_sum"}, pb_s, es);
    chk({tag, "_cout"}, 64'(pb_co), 64'(ec));
    tick();
    chk({tag, "_after"}, 64'(pb_ov), 64'd0);
  endtask

  task automatic run_c(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic ci, input logic sb, input logic [7:0] es, input logic ec);
    int lat;
    pc_a = a; pc_b = b; pc_cin = ci; pc_sub = sb; pc_iv = 1'b1;
    tick();
    pc_iv = 1'b0;
    lat   = 1;
    while (!pc_ov && lat < 12) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'd1);
    chk({tag, "_sum"}, 64'(pc_s), 64'(es));
    chk({tag, "_cout"}, 64'(pc_co), 64'(ec));
    tick();
    chk({tag, "_after"}, 64'(pc_ov), 64'd0);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    pa_fl = 1'b0; pa_iv = 1'b0; pa_or = 1'b1; pa_a = '0; pa_b = '0; pa_cin = 1'b0; pa_sub = 1'b0;
    pb_fl = 1'b0; pb_iv = 1'b0; pb_or = 1'b1; pb_a = '0; pb_b = '0; pb_cin = 1'b0; pb_sub = 1'b0;
    pc_fl = 1'b0; pc_iv = 1'b0; pc_or = 1'b1; pc_a = '0; pc_b = '0; pc_cin = 1'b0; pc_sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(pa_ov), 64'd0);
    chk("rst_sum", 64'(pa_s), 64'd0);
    chk("rst_cout", 64'(pa_co), 64'd0);
    chk("rst_b_out_valid", 64'(pb_ov), 64'd0);
`ifdef UTILS_ADDER_PIPE_FLAGS_EN
    chk("rst_zero", 64'(pa_zero), 64'd0);
    chk("rst_ovf", 64'(pa_ovf), 64'd0);
`endif
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", 64'(pa_ir), 64'd1);

    // Carry through every bit, two-cycle latency
    drive(13);
    pa_iv = 1'b0;
    chk("t1_early_valid", 64'(pa_ov), 64'd0);
    tick();
    chk("t1_valid", 64'(pa_ov), 64'd1);
    chk("t1_sum", 64'(pa_s), 64'h0);
    chk("t1_cout", 64'(pa_co), 64'd1);
`ifdef UTILS_ADDER_PIPE_FLAGS_EN
    chk("t1_zero", 64'(pa_zero), 64'd1);
    chk("t1_ovf", 64'(pa_ovf), 64'd0);
`endif

    // Subtraction: borrow, then signed overflow
    drive(14);
    drive(15);
    pa_iv = 1'b0;
    chk("t2_borrow_sum", 64'(pa_s), 64'hFFFFFFFE);
    chk("t2_borrow_cout", 64'(pa_co), 64'd0);
    tick();
    chk("t2_ovf_sum", 64'(pa_s), 64'h7FFFFFFF);
    chk("t2_ovf_cout", 64'(pa_co), 64'd1);
`ifdef UTILS_ADDER_PIPE_FLAGS_EN
    chk("t2_ovf_flag", 64'(pa_ovf), 64'd1);
`endif
    wait_drain();

    // Back-to-back stream
    for (int i = 0; i <= 12; i++) drive(i);
    pa_iv = 1'b0;
    wait_drain();

    // Backpressure with pipe full
    pa_or = 1'b0;
    drive(2);
    drive(5);
    present(7);
    for (int n = 0; n < 5; n++) begin
      chk("stall_in_ready", 64'(pa_ir), 64'd0);
      chk("stall_valid", 64'(pa_ov), 64'd1);
      chk("stall_sum", 64'(pa_s), 64'h23456789);
      tick();
    end
    pa_or = 1'b1;
    tick();
    pa_iv = 1'b0;
    wait_drain();

    // Flush with two ops in flight and a new op offered
    drive(0);
    drive(1);
    present(3);
    pa_fl = 1'b1;
    tick();
    pa_fl = 1'b0;
    pa_iv = 1'b0;
    chk("flush_valid", 64'(pa_ov), 64'd0);
    tick();
    chk("flush_valid_2", 64'(pa_ov), 64'd0);
    drive(10);
    pa_iv = 1'b0;
    tick();
    chk("post_flush_valid", 64'(pa_ov), 64'd1);
    chk("post_flush_sum", 64'(pa_s), 64'h0001FFFE);
    wait_drain();

    // Asynchronous reset mid-stream
    drive(2);
    drive(5);
    pa_iv = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(pa_ov), 64'd0);
    chk("midrst_sum", 64'(pa_s), 64'd0);
    #20;
    rst_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick();
      chk("midrst_no_output", 64'(pa_ov), 64'd0);
    end

    // Wide 4-stage instance with BLK=3
    run_b("b_sign_carry", 64'h7FFFFFFFFFFFFFFF, 64'h1, 1'b0, 1'b0, 64'h8000000000000000, 1'b0);
    run_b("b_full_carry", 64'hFFFFFFFFFFFFFFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1);
    run_b("b_borrow", 64'h0, 64'h1, 1'b0, 1'b1, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    run_b("b_mixed", 64'h123456789ABCDEF0, 64'h0FEDCBA987654321, 1'b0, 1'b0, 64'h2222222222222211, 1'b0);
    run_b("b_cin_ripple", 64'h0000FFFFFFFFFFFF, 64'h0, 1'b1, 1'b0, 64'h0001000000000000, 1'b0);

    // Single-stage 8-bit instance
    run_c("c_sign_carry", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0);
    run_c("c_full_carry", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
    run_c("c_borrow", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0);
    run_c("c_no_borrow", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1);
    run_c("c_cin", 8'h0F, 8'h10, 1'b1, 1'b0, 8'h20, 1'b0);

    wait_drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
